// File: rtl/fence_flush_sequencer_if.sv
// Request/flush handshake bundle between the commit stage, caches/TLB and the fence sequencer.
// slave = sequencer side, master = surrounding pipeline/cache side.
interface fence_flush_sequencer_if;
  logic fence_req_i;
  logic fence_i_req_i;
  logic sfence_vma_req_i;
  logic flush_dcache_req_i;
  logic no_st_pending_i;
  logic flush_dcache_ack_i;
  logic flush_dcache_o;
  logic flush_icache_o;
  logic flush_tlb_o;
  logic flush_pipeline_o;
  logic halt_commit_o;
  logic timeout_o;

  modport slave (
    input  fence_req_i, fence_i_req_i, sfence_vma_req_i, flush_dcache_req_i,
    input  no_st_pending_i, flush_dcache_ack_i,
    output flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o,
    output halt_commit_o, timeout_o
  );

  modport master (
    output fence_req_i, fence_i_req_i, sfence_vma_req_i, flush_dcache_req_i,
    output no_st_pending_i, flush_dcache_ack_i,
    input  flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o,
    input  halt_commit_o, timeout_o
  );
endinterface

// File: rtl/fence_flush_sequencer.sv
// Sequences store drain, D$/I$/TLB flushes and a final pipeline flush for FENCE-type ops; outputs are Moore.
// Define FENCE_SEQ_TIMEOUT_EN to add a watchdog that forces DRAIN/DFLUSH exits after TIMEOUT_CYCLES.
module fence_flush_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  fence_flush_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_DFLUSH = 3'd2,
    S_IFLUSH = 3'd3,
    S_TLB    = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // Bit positions within the {dc, fi, sv, fe} request vector
  localparam int unsigned OP_FE = 0;
  localparam int unsigned OP_SV = 1;
  localparam int unsigned OP_FI = 2;
  localparam int unsigned OP_DC = 3;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("fence_flush_sequencer: TIMEOUT_CYCLES out of range 1..65535");
  end

  state_e     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] op_q, op_d;
  logic [3:0] req_vec;
  logic [3:0] merged_req;
  logic       wdog_hit;

  assign req_vec    = {bus.flush_dcache_req_i, bus.fence_i_req_i,
                       bus.sfence_vma_req_i, bus.fence_req_i};
  assign merged_req = pending_q | req_vec;

`ifdef FENCE_SEQ_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wdog_q, wdog_d;
  logic        wdog_active;

  assign wdog_active = (state_q == S_DRAIN) || (state_q == S_DFLUSH);
  assign wdog_hit    = wdog_active && (wdog_q == WDOG_LIMIT);

  // Restart on every entry into a waiting state, count while waiting
  always_comb begin
    wdog_d = wdog_q;
    if ((state_d != state_q) && ((state_d == S_DRAIN) || (state_d == S_DFLUSH))) begin
      wdog_d = '0;
    end else if (wdog_active) begin
      wdog_d = wdog_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = merged_req;
    op_d      = op_q;
    case (state_q)
      S_IDLE: begin
        // Pulses arriving this cycle join the op directly, so nothing is left behind
        if (|merged_req) begin
          op_d      = merged_req;
          pending_d = '0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (bus.no_st_pending_i || wdog_hit) begin
          if (op_q[OP_FE] || op_q[OP_FI] || op_q[OP_DC]) begin
            state_d = S_DFLUSH;
          end else begin
            state_d = S_TLB;
          end
        end
      end
      S_DFLUSH: begin
        if (bus.flush_dcache_ack_i || wdog_hit) begin
          if (op_q[OP_FI]) begin
            state_d = S_IFLUSH;
          end else if (op_q[OP_SV]) begin
            state_d = S_TLB;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_IFLUSH: state_d = op_q[OP_SV] ? S_TLB : S_DONE;
      S_TLB:    state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      op_q      <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      op_q      <= op_d;
    end
  end

  assign bus.flush_dcache_o   = (state_q == S_DFLUSH);
  assign bus.flush_icache_o   = (state_q == S_IFLUSH);
  assign bus.flush_tlb_o      = (state_q == S_TLB);
  assign bus.flush_pipeline_o = (state_q == S_DONE);
  assign bus.halt_commit_o    = (state_q != S_IDLE);
  assign bus.timeout_o        = wdog_hit;

endmodule

// File: doc/fence_flush_sequencer.md
FENCE_FLUSH_SEQUENCER -- requirements
Module: fence_flush_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, sets the watchdog limit in cycles; legal range is 1..65535.
REQ-002 Port clk_i, input, 1 bit: the single clock.
REQ-003 Port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port fence_req_i, input, 1 bit: single-cycle pulse for a committed FENCE.
REQ-005 Port fence_i_req_i, input, 1 bit: single-cycle pulse for a committed FENCE.I.
REQ-006 Port sfence_vma_req_i, input, 1 bit: single-cycle pulse for a committed SFENCE.VMA.
REQ-007 Port flush_dcache_req_i, input, 1 bit: external D$ flush request pulse.
REQ-008 Port no_st_pending_i, input, 1 bit: store buffer is empty.
REQ-009 Port flush_dcache_ack_i, input, 1 bit: D$ flush is complete.
REQ-010 Port flush_dcache_o, output, 1 bit: D$ flush request, held until acknowledged.
REQ-011 Port flush_icache_o, output, 1 bit: single-cycle I$ flush.
REQ-012 Port flush_tlb_o, output, 1 bit: single-cycle TLB flush.
REQ-013 Port flush_pipeline_o, output, 1 bit: single-cycle pipeline flush that ends a sequence.
REQ-014 Port halt_commit_o, output, 1 bit: stalls the commit stage while a sequence is in progress.
REQ-015 Port timeout_o, output, 1 bit: single-cycle watchdog expiry pulse.

Function
REQ-016 The block SHALL implement FSM states IDLE, DRAIN, DFLUSH, IFLUSH, TLB and DONE; every output SHALL be a Moore decode of state.
REQ-017 The block SHALL OR request pulses into a 4-bit pending vector {dc, fi, sv, fe}; while not IDLE, new pulses SHALL accumulate and be serviced by the next sequence.
REQ-018 In IDLE with a non-zero pending vector, the FSM SHALL latch and clear the vector into an op vector and go to DRAIN on the next edge.
REQ-019 A request pulse arriving in IDLE SHALL cause DRAIN one edge later; pending capture and the IDLE exit may share an edge.
REQ-020 DRAIN SHALL exit when no_st_pending_i=1, to DFLUSH if op has fe, fi or dc, otherwise to TLB if op has sv.
REQ-021 DFLUSH SHALL drive flush_dcache_o=1; on flush_dcache_ack_i=1 it SHALL exit to IFLUSH if op has fi, else to TLB if op has sv, else to DONE.
REQ-022 IFLUSH SHALL assert flush_icache_o for one cycle, then exit to TLB if op has sv, else to DONE.
REQ-023 TLB SHALL assert flush_tlb_o for one cycle, then go to DONE.
REQ-024 DONE SHALL assert flush_pipeline_o for one cycle, then go to IDLE.
REQ-025 halt_commit_o SHALL be 1 in every state except IDLE.
REQ-026 flush_dcache_ack_i SHALL be ignored outside DFLUSH.
REQ-027 If all four requests arrive together, the sequence SHALL be DRAIN, DFLUSH, IFLUSH, TLB, DONE.

Reset
REQ-028 When rst_ni=0, the block SHALL asynchronously force state IDLE, pending=0, op=0, watchdog=0, and all outputs to 0.
REQ-029 Reset mid-sequence SHALL abandon the sequence without a flush_pipeline_o pulse; requests pending at reset SHALL be lost.

Configuration
REQ-030 With macro FENCE_SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to DRAIN or DFLUSH and increment each cycle in those states.
REQ-031 With FENCE_SEQ_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 the FSM SHALL take the exit as if the awaited condition were met, and timeout_o SHALL pulse for one cycle.
REQ-032 Without FENCE_SEQ_TIMEOUT_EN, the counter SHALL be absent, DRAIN and DFLUSH SHALL wait indefinitely, and timeout_o SHALL be tied to 0.

Verification
REQ-033 Bench SHALL cover FENCE: fence_req_i at cycle 0, no_st_pending_i=1, ack at the first DFLUSH cycle -> flush_dcache_o in cycle 2, flush_pipeline_o in cycle 3, halt_commit_o in cycles 1-3.
REQ-034 Bench SHALL cover FENCE.I: no_st_pending_i=0 until cycle 5, then ack 2 cycles after DFLUSH entry -> flush_icache_o one cycle after the ack cycle, then flush_pipeline_o.
REQ-035 Bench SHALL cover SFENCE.VMA alone -> flush_dcache_o never asserted, flush_tlb_o one cycle, then flush_pipeline_o.
REQ-036 Bench SHALL cover a fence_req_i pulse during DFLUSH of an earlier sequence -> a second full sequence starts immediately after the first DONE.
REQ-037 Bench SHALL cover TIMEOUT_CYCLES=8 with the macro defined and ack held 0 -> timeout_o pulses after 8 DFLUSH cycles, then DONE.
REQ-038 Bench SHALL cover rst_ni=0 during IFLUSH -> all outputs 0 immediately and no flush_pipeline_o pulse.
